// File: rtl/uart_fifo_bridge.sv
// rtl/uart_fifo_bridge.sv - buffered TX/RX FIFO bridge between CPU UART strobes and serial core

// Circular-buffer FIFO with registered occupancy count; full/empty come from the count.
module uart_fifo_bridge_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_req,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop_req,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             push,
    output logic             pop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rptr_q];
    assign count = count_q;

    // Accept push/pop only when the registered count allows it; pointers wrap naturally.
    always_comb begin
        push    = push_req & ~full;
        pop     = pop_req & ~empty;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (push) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Pointer and count state; cleared asynchronously so a reset discards all contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until the count says it is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// Top: TX FIFO (CPU to serial), RX FIFO (serial to CPU), registered load data and sticky flags.
module uart_fifo_bridge #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             Stall,
    input  logic [WIDTH-1:0] DataIn,
    input  logic             DataInValid,
    input  logic             DataOutReady,
    output logic [WIDTH-1:0] DataOut,
    output logic             DataOutValid,
    output logic             DataInReady,
    output logic [WIDTH-1:0] uart_tx_data,
    output logic             uart_tx_valid,
    input  logic             uart_tx_ready,
    input  logic [WIDTH-1:0] uart_rx_data,
    input  logic             uart_rx_valid,
    output logic             uart_rx_ready,
    input  logic             clr_flags,
    output logic             tx_drop,
    output logic             rx_underflow,
    output logic [CW-1:0]    tx_count,
    output logic [CW-1:0]    rx_count
);

    logic             cpu_wr;
    logic             cpu_rd;
    logic             tx_full, tx_empty, tx_push, tx_pop;
    logic             rx_full, rx_empty, rx_push, rx_pop;
    logic [WIDTH-1:0] rx_head;

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             tx_drop_q, tx_drop_d;
    logic             rx_underflow_q, rx_underflow_d;

    // A stalled pipeline stage must not commit its UART strobes.
    assign cpu_wr = DataInValid & ~Stall;
    assign cpu_rd = DataOutReady & ~Stall;

    uart_fifo_bridge_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_tx_fifo (
        .clk      (CLK),
        .rst_n    (reset_n),
        .push_req (cpu_wr),
        .wdata    (DataIn),
        .pop_req  (uart_tx_ready),
        .head     (uart_tx_data),
        .count    (tx_count),
        .full     (tx_full),
        .empty    (tx_empty),
        .push     (tx_push),
        .pop      (tx_pop)
    );

    uart_fifo_bridge_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_rx_fifo (
        .clk      (CLK),
        .rst_n    (reset_n),
        .push_req (uart_rx_valid),
        .wdata    (uart_rx_data),
        .pop_req  (cpu_rd),
        .head     (rx_head),
        .count    (rx_count),
        .full     (rx_full),
        .empty    (rx_empty),
        .push     (rx_push),
        .pop      (rx_pop)
    );

    // Handshake status is derived from registered counts only, so ready/valid never loop back.
    assign uart_tx_valid = ~tx_empty;
    assign DataInReady   = ~tx_full;
    assign uart_rx_ready = ~rx_full;
    assign DataOutValid  = ~rx_empty;
    assign DataOut       = data_out_q;
    assign tx_drop       = tx_drop_q;
    assign rx_underflow  = rx_underflow_q;

    // Load data updates only on a real RX pop; error events win over a coincident clear.
    always_comb begin
        data_out_d     = data_out_q;
        tx_drop_d      = tx_drop_q;
        rx_underflow_d = rx_underflow_q;
        if (rx_pop) begin
            data_out_d = rx_head;
        end
        if (clr_flags) begin
            tx_drop_d      = 1'b0;
            rx_underflow_d = 1'b0;
        end
        if (cpu_wr & tx_full) begin
            tx_drop_d = 1'b1;
        end
        if (cpu_rd & rx_empty) begin
            rx_underflow_d = 1'b1;
        end
    end

    // Load-data register and sticky error flags.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q     <= '0;
            tx_drop_q      <= 1'b0;
            rx_underflow_q <= 1'b0;
        end else begin
            data_out_q     <= data_out_d;
            tx_drop_q      <= tx_drop_d;
            rx_underflow_q <= rx_underflow_d;
        end
    end

    // Handshake qualifiers kept for observability alongside the counts.
    logic unused_ok;
    assign unused_ok = tx_push ^ tx_pop ^ rx_push;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb/tb_uart_fifo_bridge.sv - directed self-checking bench for uart_fifo_bridge

module tb_uart_fifo_bridge;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CLK;
    logic          reset_n;
    logic          Stall;
    logic [7:0]    DataIn;
    logic          DataInValid;
    logic          DataOutReady;
    logic [7:0]    DataOut;
    logic          DataOutValid;
    logic          DataInReady;
    logic [7:0]    uart_tx_data;
    logic          uart_tx_valid;
    logic          uart_tx_ready;
    logic [7:0]    uart_rx_data;
    logic          uart_rx_valid;
    logic          uart_rx_ready;
    logic          clr_flags;
    logic          tx_drop;
    logic          rx_underflow;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] rx_count;

    int n_tests;
    int n_fail;

    logic [7:0] tq[$];
    logic [7:0] rq[$];
    logic [7:0] exp_out;

    uart_fifo_bridge #(.DEPTH(DEPTH), .WIDTH(8)) dut (
        .CLK           (CLK),
        .reset_n       (reset_n),
        .Stall         (Stall),
        .DataIn        (DataIn),
        .DataInValid   (DataInValid),
        .DataOutReady  (DataOutReady),
        .DataOut       (DataOut),
        .DataOutValid  (DataOutValid),
        .DataInReady   (DataInReady),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .clr_flags     (clr_flags),
        .tx_drop       (tx_drop),
        .rx_underflow  (rx_underflow),
        .tx_count      (tx_count),
        .rx_count      (rx_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset_n       = 1'b0;
        Stall         = 1'b0;
        DataIn        = '0;
        DataInValid   = 1'b0;
        DataOutReady  = 1'b0;
        uart_tx_ready = 1'b0;
        uart_rx_data  = '0;
        uart_rx_valid = 1'b0;
        clr_flags     = 1'b0;
        exp_out       = '0;

        // reset state
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check("rst_in_ready",  32'(DataInReady),   32'd1);
        check("rst_out_valid", 32'(DataOutValid),  32'd0);
        check("rst_tx_valid",  32'(uart_tx_valid), 32'd0);
        check("rst_rx_ready",  32'(uart_rx_ready), 32'd1);
        check("rst_tx_count",  32'(tx_count),      32'd0);
        check("rst_data_out",  32'(DataOut),       32'd0);
        check("rst_tx_drop",   32'(tx_drop),       32'd0);

        // three writes held back, then drained in order
        for (int i = 0; i < 3; i++) begin
            DataIn      = 8'h41 + 8'(i);
            DataInValid = 1'b1;
            tick();
            if (i == 0) check("wr_to_tx_valid", 32'(uart_tx_valid), 32'd1);
        end
        DataInValid = 1'b0;
        #1;
        check("tx_count_3", 32'(tx_count), 32'd3);
        check("tx_hold_head", 32'(uart_tx_data), 32'h41);
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("tx_order", 32'(uart_tx_data), 32'h41 + 32'(i));
            tick();
        end
        uart_tx_ready = 1'b0;
        #1;
        check("tx_count_drained", 32'(tx_count), 32'd0);
        check("tx_valid_drained", 32'(uart_tx_valid), 32'd0);

        // overflow: ninth byte dropped, flag sticky, then cleared
        for (int i = 0; i < 9; i++) begin
            DataIn      = 8'(i);
            DataInValid = 1'b1;
            tick();
            if (i == 7) begin
                check("full_in_ready", 32'(DataInReady), 32'd0);
                check("full_count",    32'(tx_count),    32'd8);
                check("full_no_drop",  32'(tx_drop),     32'd0);
            end
        end
        DataInValid = 1'b0;
        check("drop_flag",  32'(tx_drop),  32'd1);
        check("drop_count", 32'(tx_count), 32'd8);
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("drain_order", 32'(uart_tx_data), 32'(i));
            tick();
        end
        uart_tx_ready = 1'b0;
        #1;
        check("drain_empty", 32'(tx_count), 32'd0);
        check("drop_sticky", 32'(tx_drop),  32'd1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("drop_cleared", 32'(tx_drop), 32'd0);

        // serial push then CPU read
        uart_rx_data  = 8'h55;
        uart_rx_valid = 1'b1;
        tick();
        uart_rx_valid = 1'b0;
        check("rx_valid_lat", 32'(DataOutValid), 32'd1);
        check("rx_count_1",   32'(rx_count),     32'd1);
        DataOutReady = 1'b1;
        tick();
        DataOutReady = 1'b0;
        check("rd_data",       32'(DataOut),      32'h55);
        check("rd_count",      32'(rx_count),     32'd0);
        check("rd_out_valid",  32'(DataOutValid), 32'd0);

        // underflow coinciding with a push
        DataOutReady  = 1'b1;
        uart_rx_data  = 8'h7E;
        uart_rx_valid = 1'b1;
        tick();
        DataOutReady  = 1'b0;
        uart_rx_valid = 1'b0;
        check("uf_flag",  32'(rx_underflow), 32'd1);
        check("uf_hold",  32'(DataOut),      32'h55);
        check("uf_count", 32'(rx_count),     32'd1);
        DataOutReady = 1'b1;
        tick();
        DataOutReady = 1'b0;
        check("uf_next_read", 32'(DataOut), 32'h7E);
        // clear coinciding with a fresh underflow: set wins
        clr_flags    = 1'b1;
        DataOutReady = 1'b1;
        tick();
        DataOutReady = 1'b0;
        check("uf_set_wins", 32'(rx_underflow), 32'd1);
        tick();
        clr_flags = 1'b0;
        check("uf_cleared", 32'(rx_underflow), 32'd0);

        // stalled strobes have no effect
        Stall        = 1'b1;
        DataIn       = 8'hEE;
        DataInValid  = 1'b1;
        DataOutReady = 1'b1;
        repeat (3) tick();
        Stall        = 1'b0;
        DataInValid  = 1'b0;
        DataOutReady = 1'b0;
        check("stall_tx_count", 32'(tx_count),     32'd0);
        check("stall_uf",       32'(rx_underflow), 32'd0);
        check("stall_drop",     32'(tx_drop),      32'd0);

        // 20 mixed cycles on both FIFOs against queue models; pointers wrap twice
        exp_out = DataOut;
        for (int i = 0; i < 20; i++) begin
            DataIn        = 8'h30 + 8'(i);
            DataInValid   = 1'b1;
            uart_tx_ready = (i % 3) != 0;
            uart_rx_data  = 8'hA0 + 8'(i);
            uart_rx_valid = 1'b1;
            DataOutReady  = (i % 4) != 0;
            #1;
            if (tq.size() > 0) check("mix_tx_head", 32'(uart_tx_data), 32'(tq[0]));
            if (uart_tx_ready && tq.size() > 0) void'(tq.pop_front());
            tq.push_back(DataIn);
            if (DataOutReady && rq.size() > 0) exp_out = rq.pop_front();
            rq.push_back(uart_rx_data);
            tick();
            check("mix_rx_data", 32'(DataOut), 32'(exp_out));
        end
        DataInValid   = 1'b0;
        uart_tx_ready = 1'b0;
        uart_rx_valid = 1'b0;
        DataOutReady  = 1'b0;
        #1;
        check("mix_tx_count", 32'(tx_count), 32'(tq.size()));
        check("mix_rx_count", 32'(rx_count), 32'(rq.size()));
        check("mix_flags",    32'({tx_drop, rx_underflow}), 32'd0);

        // asynchronous reset between clock edges
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_tx_count", 32'(tx_count),      32'd0);
        check("arst_rx_count", 32'(rx_count),      32'd0);
        check("arst_out",      32'(DataOut),       32'd0);
        check("arst_tx_valid", 32'(uart_tx_valid), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_valid", 32'(DataOutValid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_fifo_bridge.md
Name: uart_fifo_bridge

Overview:
Buffered bridge between the CPU datapath's memory-mapped UART ports and the serial UART transceiver core. It holds one TX FIFO (CPU to serial) and one RX FIFO (serial to CPU), and generates the status bits the datapath reads back as DataInReady and DataOutValid. It sits directly downstream of the datapath's stage-2/3 UART strobes. Load data is presented one cycle after the read strobe, matching the datapath's registered write-back select.

Parameters:
DEPTH, 8, entries per FIFO; power of two, 2 to 64.
WIDTH, 8, data width in bits; fixed at 8 for this datapath.
CW, $clog2(DEPTH)+1, occupancy counter width (derived; not overridable).

Ports:
CLK  in  1  system clock; all state is updated on the rising edge.
reset_n  in  1  reset; asynchronous assert, active-low.
Stall  in  1  pipeline stall; when high, CPU strobes are ignored.
DataIn  in  8  CPU store byte (datapath rd2[7:0]).
DataInValid  in  1  CPU TX write strobe (WEUART).
DataOutReady  in  1  CPU RX read strobe (REUART).
DataOut  out  8  last byte popped from RX FIFO (registered).
DataOutValid  out  1  RX FIFO not empty.
DataInReady  out  1  TX FIFO not full.
uart_tx_data  out  8  TX FIFO head.
uart_tx_valid  out  1  TX FIFO not empty.
uart_tx_ready  in  1  serial core accepts the byte.
uart_rx_data  in  8  received byte.
uart_rx_valid  in  1  received byte available.
uart_rx_ready  out  1  RX FIFO not full.
clr_flags  in  1  synchronous clear of the sticky error flags.
tx_drop  out  1  sticky flag: a CPU write arrived while the TX FIFO was full.
rx_underflow  out  1  sticky flag: a CPU read arrived while the RX FIFO was empty.
tx_count  out  CW  TX occupancy, 0..DEPTH.
rx_count  out  CW  RX occupancy, 0..DEPTH.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All pointers and counts go to 0; DataOut=0; tx_drop=0; rx_underflow=0.
  - Resulting outputs: uart_tx_valid=0, DataOutValid=0, DataInReady=1, uart_rx_ready=1.
  - Reset asserted mid-transfer discards both FIFO contents; no partial state survives.
- Qualified strobes: cpu_wr = DataInValid & ~Stall; cpu_rd = DataOutReady & ~Stall.
- Each FIFO is a circular buffer with log2(DEPTH)-bit read and write pointers that wrap from DEPTH-1 to 0.
- Full and empty are derived from the registered count: full = (count==DEPTH), empty = (count==0).
- TX push: cpu_wr & ~tx_full writes DataIn at wptr.
  - cpu_wr & tx_full drops the byte and sets tx_drop; this holds even if a TX pop happens in the same cycle.
- TX pop: uart_tx_valid & uart_tx_ready.
  - uart_tx_data and uart_tx_valid are combinational from storage/count and stay stable while valid & ~ready.
- RX push: uart_rx_valid & uart_rx_ready. RX pop: cpu_rd & ~rx_empty.
  - On RX pop, DataOut is loaded with the head byte at the clock edge, so the CPU samples it in the following cycle.
  - DataOut holds its value until the next successful pop.
- cpu_rd & rx_empty: no pop, DataOut unchanged, rx_underflow set.
  - This holds even if an RX push happens in the same cycle; that push is still accepted.
- Simultaneous push and pop on a non-empty, non-full FIFO: both occur and the count is unchanged.
- Full FIFO plus pop: the count decrements; the push side was already blocked by ready/full.
- Empty FIFO plus push: the count increments; a pop is not possible.
- Count update: count <= count + push - pop, never outside 0..DEPTH.
- Sticky flags: clr_flags clears both flags.
  - If clr_flags coincides with a new error event in the same cycle, the set wins.
- Latency:
  - CPU write to uart_tx_valid: 1 cycle.
  - uart_rx_valid accepted to DataOutValid: 1 cycle.
  - CPU read to DataOut updated: 1 cycle.
- No combinational path from uart_tx_ready to uart_tx_valid, or from uart_rx_valid to uart_rx_ready.

Test Plan:
1. Release reset with no traffic -> DataInReady=1, DataOutValid=0, uart_tx_valid=0, uart_rx_ready=1, tx_count=0, DataOut=0.
2. CPU writes 0x41, 0x42, 0x43 on consecutive cycles with uart_tx_ready=0, then ready=1 -> tx_count=3; uart_tx_data emits 0x41, 0x42, 0x43 in order, one per cycle; tx_count returns to 0.
3. Nine CPU writes (0x00..0x08) with uart_tx_ready=0, DEPTH=8 -> DataInReady=0 after the 8th; 0x08 dropped; tx_drop=1; drain yields 0x00..0x07 only; clr_flags -> tx_drop=0.
4. Serial core pushes 0x55, then CPU read strobe -> DataOutValid=1 one cycle after the push; DataOut=0x55 one cycle after the read; rx_count=0; DataOutValid=0.
5. Read strobe with RX empty and uart_rx_valid=1 (0x7E) in the same cycle -> rx_underflow=1, DataOut unchanged, rx_count=1; the next read returns 0x7E.
6. Read/write strobes held with Stall=1 -> no count change, no flags set; 20 mixed push/pop cycles that wrap the pointers twice -> data order preserved. Assert reset_n low mid-stream -> counts=0 immediately, asynchronously.
